// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared types and constants for the sprite overlay
// Border feature constants are consumed only when SPRITE_BORDER_EN is defined.
package sprite_pkg;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  localparam int      BORDER_W   = 4;
  localparam rgb444_t BORDER_RGB = '{r: 4'hF, g: 4'h0, b: 4'h0};

  function automatic int base_x(input int h_active, input int sprite_w);
    return (h_active - sprite_w) / 2;
  endfunction

  function automatic int base_y(input int v_active, input int sprite_h);
    return (v_active - sprite_h) / 2;
  endfunction

endpackage

// File: rtl/sprite_engine_if.sv
// rtl/sprite_engine_if.sv - sprite ROM bus between engine (master) and synchronous ROM (slave)
interface sprite_engine_if #(
  parameter int ADDR_W = 9
);
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_data;

  modport master (output rom_addr, input rom_data);
  modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_pos_clamp.sv
// rtl/sprite_pos_clamp.sv - per-sprite offset add, clamp, shadow position and edge-hit counter
module sprite_pos_clamp
  import sprite_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPRITE_W = 16,
  parameter int SPRITE_H = 16,
  parameter int COUNT_W  = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               frame_start_i,
  input  logic [9:0]         offset_x_i,
  input  logic [9:0]         offset_y_i,
  output logic [9:0]         pos_x_o,
  output logic [9:0]         pos_y_o,
  output logic               clamped_o,
  output logic [COUNT_W-1:0] hit_count_o
);

  localparam int BX    = base_x(H_ACTIVE, SPRITE_W);
  localparam int BY    = base_y(V_ACTIVE, SPRITE_H);
  localparam int MAX_X = H_ACTIVE - SPRITE_W;
  localparam int MAX_Y = V_ACTIVE - SPRITE_H;

  logic [11:0]        px, py;
  logic               x_lo, x_hi, y_lo, y_hi;
  logic [9:0]         pos_x_d, pos_y_d, pos_x_q, pos_y_q;
  logic               clamped_d, clamped_q;
  logic [COUNT_W-1:0] hit_d, hit_q;

  // 12-bit two's-complement sum; bit 11 is the sign.
  assign px = 12'(BX) + {{2{offset_x_i[9]}}, offset_x_i};
  assign py = 12'(BY) + {{2{offset_y_i[9]}}, offset_y_i};

  always_comb begin
    x_lo      = px[11];
    x_hi      = !px[11] && (px[10:0] > 11'(MAX_X));
    y_lo      = py[11];
    y_hi      = !py[11] && (py[10:0] > 11'(MAX_Y));
    pos_x_d   = x_lo ? 10'd0 : (x_hi ? 10'(MAX_X) : px[9:0]);
    pos_y_d   = y_lo ? 10'd0 : (y_hi ? 10'(MAX_Y) : py[9:0]);
    clamped_d = x_lo | x_hi | y_lo | y_hi;
    hit_d     = hit_q;
    if (clamped_d && !clamped_q && (hit_q != '1)) begin
      hit_d = hit_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pos_x_q   <= 10'(BX);
      pos_y_q   <= 10'(BY);
      clamped_q <= 1'b0;
      hit_q     <= '0;
    end else if (frame_start_i) begin
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      clamped_q <= clamped_d;
      hit_q     <= hit_d;
    end
  end

  assign pos_x_o     = pos_x_q;
  assign pos_y_o     = pos_y_q;
  assign clamped_o   = clamped_q;
  assign hit_count_o = hit_q;

endmodule

// File: rtl/sprite_engine.sv
// rtl/sprite_engine.sv - multi-sprite overlay: hit test, priority, ROM address, 2-cycle colour pipe
// Optional SPRITE_BORDER_EN paints the outer background ring red while any sprite is clamped.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 2,
  parameter int          SPRITE_W    = 16,
  parameter int          SPRITE_H    = 16,
  parameter int          H_ACTIVE    = 640,
  parameter int          V_ACTIVE    = 480,
  parameter int          COUNT_W     = 16,
  parameter logic [11:0] TRANSPARENT = 12'h000
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [9:0]                     col,
  input  logic [9:0]                     row,
  input  logic                           frame_start,
  input  logic [10*NUM_SPRITES-1:0]      offset_x,
  input  logic [10*NUM_SPRITES-1:0]      offset_y,
  sprite_engine_if.master                rom_bus,
  output logic [3:0]                     red,
  output logic [3:0]                     green,
  output logic [3:0]                     blue,
  output logic [NUM_SPRITES-1:0]         clamped,
  output logic [COUNT_W*NUM_SPRITES-1:0] hit_count
);

  localparam int ADDR_W = $clog2(NUM_SPRITES * SPRITE_W * SPRITE_H);

  logic [9:0] pos_x [NUM_SPRITES];
  logic [9:0] pos_y [NUM_SPRITES];

  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    sprite_pos_clamp #(
      .H_ACTIVE (H_ACTIVE),
      .V_ACTIVE (V_ACTIVE),
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .COUNT_W  (COUNT_W)
    ) u_clamp (
      .clock         (clock),
      .reset_n       (reset_n),
      .frame_start_i (frame_start),
      .offset_x_i    (offset_x[10*i +: 10]),
      .offset_y_i    (offset_y[10*i +: 10]),
      .pos_x_o       (pos_x[i]),
      .pos_y_o       (pos_y[i]),
      .clamped_o     (clamped[i]),
      .hit_count_o   (hit_count[COUNT_W*i +: COUNT_W])
    );
  end

  logic [NUM_SPRITES-1:0] covers;
  logic                   hit_d, blank_d;
  logic [ADDR_W-1:0]      addr_d;

  always_comb begin
    covers = '0;
    for (int i = 0; i < NUM_SPRITES; i++) begin
      covers[i] = ({1'b0, col} >= {1'b0, pos_x[i]}) &&
                  ({1'b0, col} <  ({1'b0, pos_x[i]} + 11'(SPRITE_W))) &&
                  ({1'b0, row} >= {1'b0, pos_y[i]}) &&
                  ({1'b0, row} <  ({1'b0, pos_y[i]} + 11'(SPRITE_H)));
    end
  end

  // Walk from highest to lowest index so the lowest-index covering sprite is written last.
  always_comb begin
    hit_d  = 1'b0;
    addr_d = '0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (covers[i]) begin
        hit_d  = 1'b1;
        addr_d = ADDR_W'(i * SPRITE_W * SPRITE_H
                         + (int'(row) - int'(pos_y[i])) * SPRITE_W
                         + (int'(col) - int'(pos_x[i])));
      end
    end
    blank_d = ({1'b0, col} >= 11'(H_ACTIVE)) || ({1'b0, row} >= 11'(V_ACTIVE));
  end

  logic [ADDR_W-1:0] rom_addr_q;
  logic              s0_hit_q, s0_blank_q;
  logic              s1_hit_q, s1_blank_q;
  rgb444_t           rgb_d, rgb_q;

`ifdef SPRITE_BORDER_EN
  logic ring_d, s0_ring_q, s1_ring_q;

  assign ring_d = ({1'b0, col} < 11'(BORDER_W)) ||
                  ({1'b0, col} >= 11'(H_ACTIVE - BORDER_W)) ||
                  ({1'b0, row} < 11'(BORDER_W)) ||
                  ({1'b0, row} >= 11'(V_ACTIVE - BORDER_W));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s0_ring_q <= 1'b0;
      s1_ring_q <= 1'b0;
    end else begin
      s0_ring_q <= ring_d;
      s1_ring_q <= s0_ring_q;
    end
  end
`endif

  // A transparent winner falls through to background; lower sprites are never consulted.
  always_comb begin
    rgb_d = '0;
    if (!s1_blank_q) begin
      if (s1_hit_q && (rom_bus.rom_data != TRANSPARENT)) begin
        rgb_d = rgb444_t'(rom_bus.rom_data);
      end
`ifdef SPRITE_BORDER_EN
      else if (s1_ring_q && (|clamped)) begin
        rgb_d = BORDER_RGB;
      end
`endif
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr_q <= '0;
      s0_hit_q   <= 1'b0;
      s0_blank_q <= 1'b1;
      s1_hit_q   <= 1'b0;
      s1_blank_q <= 1'b1;
      rgb_q      <= '0;
    end else begin
      rom_addr_q <= addr_d;
      s0_hit_q   <= hit_d;
      s0_blank_q <= blank_d;
      s1_hit_q   <= s0_hit_q;
      s1_blank_q <= s0_blank_q;
      rgb_q      <= rgb_d;
    end
  end

  assign rom_bus.rom_addr = rom_addr_q;
  assign red              = rgb_q.r;
  assign green            = rgb_q.g;
  assign blue             = rgb_q.b;

endmodule

// File: tb/tb_sprite_engine.sv
// tb/tb_sprite_engine.sv - directed self-checking bench for sprite_engine
// Border expectations follow SPRITE_BORDER_EN.
module tb_sprite_engine;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [9:0]  col, row;
  logic        frame_start;
  logic [19:0] offset_x, offset_y;
  logic [3:0]  red, green, blue;
  logic [1:0]  clamped;
  logic [31:0] hit_count;
  logic [3:0]  red2, green2, blue2;
  logic [1:0]  clamped2;
  logic [3:0]  hit_count2;

  logic [11:0] rom_mem [512];
  int checks = 0;
  int passes = 0;

  sprite_engine_if #(.ADDR_W(9)) rom_bus ();
  sprite_engine_if #(.ADDR_W(9)) rom_bus2 ();

  always #5 clock = ~clock;

  always @(posedge clock) rom_bus.rom_data <= rom_mem[rom_bus.rom_addr];
  assign rom_bus2.rom_data = 12'h000;

  sprite_engine dut (
    .clock (clock), .reset_n (reset_n), .col (col), .row (row),
    .frame_start (frame_start), .offset_x (offset_x), .offset_y (offset_y),
    .rom_bus (rom_bus.master), .red (red), .green (green), .blue (blue),
    .clamped (clamped), .hit_count (hit_count)
  );

  sprite_engine #(.COUNT_W(2)) dut2 (
    .clock (clock), .reset_n (reset_n), .col (col), .row (row),
    .frame_start (frame_start), .offset_x (offset_x), .offset_y (offset_y),
    .rom_bus (rom_bus2.master), .red (red2), .green (green2), .blue (blue2),
    .clamped (clamped2), .hit_count (hit_count2)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic run_pixel(input logic [9:0] c, input logic [9:0] r,
                           output logic [8:0] addr, output logic [11:0] rgb);
    col = c;
    row = r;
    tick();
    addr = rom_bus.rom_addr;
    tick();
    tick();
    rgb = {red, green, blue};
  endtask

  task automatic test_reset();
    logic [8:0]  a;
    logic [11:0] c;
    reset_n = 1'b0;
    tick();
    tick();
    checks++; if ({red, green, blue} !== 12'h000) $display("FAIL reset_rgb got %h want 000", {red, green, blue}); else passes++;
    checks++; if (rom_bus.rom_addr !== 9'd0) $display("FAIL reset_addr got %0d want 0", rom_bus.rom_addr); else passes++;
    checks++; if (clamped !== 2'b00) $display("FAIL reset_clamped got %b want 00", clamped); else passes++;
    checks++; if (hit_count !== 32'd0) $display("FAIL reset_hits got %h want 0", hit_count); else passes++;
    reset_n = 1'b1;
    tick();
    run_pixel(10'd313, 10'd233, a, c);
    checks++; if (a !== 9'd17) $display("FAIL reset_base_pos got %0d want 17", a); else passes++;
  endtask

  task automatic test_centre();
    logic [8:0]  a;
    logic [11:0] c;
    offset_x = '0;
    offset_y = '0;
    pulse_fs();
    run_pixel(10'd312, 10'd232, a, c);
    checks++; if (a !== 9'd0) $display("FAIL centre_addr got %0d want 0", a); else passes++;
    checks++; if (c !== 12'hABC) $display("FAIL centre_rgb got %h want ABC", c); else passes++;
    run_pixel(10'd311, 10'd232, a, c);
    checks++; if (c !== 12'h000) $display("FAIL left_of_sprite_rgb got %h want 000", c); else passes++;
    run_pixel(10'd327, 10'd247, a, c);
    checks++; if (a !== 9'd255) $display("FAIL corner_addr got %0d want 255", a); else passes++;
    checks++; if (c !== 12'h6FA) $display("FAIL corner_rgb got %h want 6FA", c); else passes++;
    run_pixel(10'd328, 10'd232, a, c);
    checks++; if (a !== 9'd0 || c !== 12'h000) $display("FAIL right_of_sprite got %0d/%h want 0/000", a, c); else passes++;
    run_pixel(10'd700, 10'd10, a, c);
    checks++; if (c !== 12'h000) $display("FAIL blank_rgb got %h want 000", c); else passes++;
  endtask

  task automatic test_clamp_count();
    logic [8:0]  a;
    logic [11:0] c;
    offset_x[9:0] = 10'h270;
    pulse_fs();
    checks++; if (clamped !== 2'b01) $display("FAIL clamp_flag got %b want 01", clamped); else passes++;
    checks++; if (hit_count[15:0] !== 16'd1) $display("FAIL clamp_hit0 got %0d want 1", hit_count[15:0]); else passes++;
    run_pixel(10'd5, 10'd233, a, c);
    checks++; if (a !== 9'd21) $display("FAIL clamp_posx0 got %0d want 21", a); else passes++;
    run_pixel(10'd16, 10'd233, a, c);
    checks++; if (a !== 9'd0) $display("FAIL clamp_right_edge got %0d want 0", a); else passes++;
    for (int k = 0; k < 3; k++) pulse_fs();
    checks++; if (hit_count[15:0] !== 16'd1) $display("FAIL clamp_hold got %0d want 1", hit_count[15:0]); else passes++;
    offset_x = '0;
    pulse_fs();
    checks++; if (clamped !== 2'b00) $display("FAIL unclamp got %b want 00", clamped); else passes++;
    offset_x = {10'd400, 10'h270};
    pulse_fs();
    checks++; if (hit_count !== {16'd1, 16'd2}) $display("FAIL reclamp_hits got %h want 00010002", hit_count); else passes++;
    checks++; if (clamped !== 2'b11) $display("FAIL reclamp_flags got %b want 11", clamped); else passes++;
    run_pixel(10'd639, 10'd232, a, c);
    checks++; if (a !== 9'd271) $display("FAIL clamp_max_x got %0d want 271", a); else passes++;
  endtask

  task automatic test_priority();
    logic [8:0]  a;
    logic [11:0] c;
    offset_x = '0;
    offset_y = '0;
    pulse_fs();
    run_pixel(10'd313, 10'd233, a, c);
    checks++; if (a !== 9'd17) $display("FAIL priority_addr got %0d want 17", a); else passes++;
    checks++; if (c !== 12'h000) $display("FAIL transparent_rgb got %h want 000", c); else passes++;
  endtask

  task automatic test_border();
    logic [8:0]  a;
    logic [11:0] c;
    logic [11:0] ring_exp;
`ifdef SPRITE_BORDER_EN
    ring_exp = 12'hF00;
`else
    ring_exp = 12'h000;
`endif
    offset_x[9:0] = 10'h270;
    pulse_fs();
    run_pixel(10'd0, 10'd100, a, c);
    checks++; if (c !== ring_exp) $display("FAIL border_ring got %h want %h", c, ring_exp); else passes++;
    run_pixel(10'd4, 10'd100, a, c);
    checks++; if (c !== 12'h000) $display("FAIL border_inside got %h want 000", c); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [8:0]  a;
    logic [11:0] c;
    run_pixel(10'd5, 10'd233, a, c);
    checks++; if (c !== 12'h094) $display("FAIL inflight_rgb got %h want 094", c); else passes++;
    #2 reset_n = 1'b0;
    #1;
    checks++; if ({red, green, blue} !== 12'h000) $display("FAIL midreset_rgb got %h want 000", {red, green, blue}); else passes++;
    checks++; if (hit_count !== 32'd0 || hit_count2 !== 4'd0) $display("FAIL midreset_hits got %h/%h want 0/0", hit_count, hit_count2); else passes++;
    checks++; if (rom_bus.rom_addr !== 9'd0 || clamped !== 2'b00) $display("FAIL midreset_addr_clamp got %0d/%b want 0/00", rom_bus.rom_addr, clamped); else passes++;
    #1 reset_n = 1'b1;
    run_pixel(10'd313, 10'd233, a, c);
    checks++; if (a !== 9'd17) $display("FAIL midreset_base_pos got %0d want 17", a); else passes++;
  endtask

  task automatic test_saturation();
    offset_x = '0;
    for (int k = 0; k < 5; k++) begin
      offset_x[9:0] = 10'h270;
      pulse_fs();
      offset_x[9:0] = 10'h000;
      pulse_fs();
    end
    checks++; if (hit_count2[1:0] !== 2'd3) $display("FAIL sat_count_w2 got %0d want 3", hit_count2[1:0]); else passes++;
    checks++; if (hit_count[15:0] !== 16'd5) $display("FAIL sat_count_w16 got %0d want 5", hit_count[15:0]); else passes++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_mem[i] = 12'(i * 7 + 1);
    rom_mem[0]  = 12'hABC;
    rom_mem[17] = 12'h000;
    reset_n     = 1'b0;
    col         = 10'd700;
    row         = 10'd500;
    frame_start = 1'b0;
    offset_x    = '0;
    offset_y    = '0;
    #1;
    test_reset();
    test_centre();
    test_clamp_count();
    test_priority();
    test_border();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
